crc_wr_burst_gen: RTL and testbench
===================================

// Module: crc_wr_burst_gen
// PURPOSE
//  DDR5 write-CRC generator for the PHY write datapath: one CRC-8 per byte lane over a whole BL16/BL8 burst.
//  Runtime-selectable x4/x8/x16 device mode. Beat counting and BL8 all-ones padding are done internally.
//  Sits between the write-data serializer feed and the DQ mux; the code is muxed onto the burst tail by the caller.
// PARAMETERS
//  NUM_LANES  2     byte lanes (x16 = 2); CRC engines instantiated = NUM_LANES
//  LANE_W     8     DQ bits per lane
//  POLY       8'h07 CRC-8 polynomial x^8+x^2+x+1
//  INIT       8'h00 CRC seed at burst start
// PORTS
//  i_clk          in   1                      clock
//  i_reset        in   1                      synchronous, active-high reset
//  i_crc_en       in   1                      data beat valid (1 beat = 2 UI)
//  i_crc_in_data  in   2*NUM_LANES*LANE_W     lane L: UI even = [L*2W +: W], UI odd = [L*2W+W +: W]
//  i_mode         in   2                      0=x4, 1=x8, 2=x16; 3 reserved, treated as x8
//  i_bl8          in   1                      1=BL8 (4 beats + 4 pad), 0=BL16 (8 beats)
//  o_busy         out  1                      high in PAD/DONE; i_crc_en must be low
//  o_crc_valid    out  1                      one-cycle pulse, o_crc_code valid
//  o_crc_code     out  8*NUM_LANES            lane L CRC at [8L +: 8]; inactive lanes = 8'h00
//  o_overrun      out  1                      sticky; beat arrived while o_busy; cleared by reset only
// BEHAVIOUR
//  Reset: FSM=IDLE, counter=0, CRCs=INIT; o_busy=0, o_crc_valid=0, o_crc_code=0, o_overrun=0.
//  Bit order: serial, MSB-first shift; UI ascending, DQ ascending within a UI; 2 UI folded per clock.
//  Active DQ per lane: x4 lane0 DQ[3:0] only (DQ[7:4] ignored); x8 lane0 all 8; x16 lanes 0..NUM_LANES-1.
//  FSM IDLE: i_crc_en -> latch i_mode/i_bl8, fold beat 0 from INIT, cnt=1, -> DATA.
//  DATA: i_crc_en folds beat, cnt++; en low = stall, state held, no timeout.
//   Last beat (cnt=7 BL16 / cnt=3 BL8) folds, then -> DONE (BL16) or PAD (BL8).
//  PAD: 4 cycles folding all-ones into active lanes; i_crc_en ignored. -> DONE.
//  DONE: o_crc_valid=1 with registered codes for 1 cycle; CRCs reseed to INIT; -> IDLE.
//  Latency: BL16 valid 1 clk after last beat; BL8 valid 5 clk after last beat.
//  Back-to-back: IDLE->DATA, so a new burst starts the cycle after o_crc_valid (1-cycle bubble mandatory).
//  Mode/BL changes mid-burst are ignored (latched values used).
//  o_crc_code holds its value until the next o_crc_valid.
//  i_crc_en while o_busy: beat dropped, o_overrun set, CRC unaffected.
//  i_reset mid-burst: next cycle IDLE with all reset values; partial burst discarded, no valid pulse.
// STRUCTURE
//  Package crc_wr_pkg:
//   - typedef enum {IDLE,DATA,PAD,DONE} crc_state_e
//   - typedef enum logic[1:0] {MODE_X4,MODE_X8,MODE_X16} dev_mode_e
//   - localparams BEATS_BL16=8, BEATS_BL8=4, PAD_BEATS=4
//   - function crc8_fold(crc, data, nbits)
//  Sub-module crc8_lane_engine (one per lane): seed/fold/hold control, combinational 2*LANE_W-bit fold
//   with width mask for x4, 8-bit register.
//  Top holds FSM, beat/pad counter, mode latch, output registers.
// TESTING
//  - x8 BL16, 8 beats of 16'h0000 -> o_crc_valid 1 clk after beat 8, o_crc_code[7:0]=8'h00.
//  - x8 BL16, data 0 except beat 8 bit[15] (UI15 DQ7)=1 -> 8'h07.
//    Same on x16 lane 1 only -> o_crc_code=16'h0700.
//  - x8 BL16, 8 beats all-ones -> 8'hFA. x4 BL16 all-ones -> 8'hD7.
//  - x4 BL8, 4 beats 8'hFF -> o_busy 4 clk (PAD) + 1 clk (DONE); valid 5 clk after beat 4, code 8'hD7 (= x4 BL16 all-ones).
//  - x8 BL16 all-ones with i_crc_en low 3 clk after beat 3 -> same 8'hFA, valid 1 clk after beat 8.
//    Second burst started the cycle after valid -> correct code.
//  - x4 BL8: beat during PAD -> o_overrun=1, code still 8'hD7.
//    i_reset at beat 5 of a BL16 burst -> no valid pulse; next all-zero burst gives 8'h00.

Source files
------------

// File: rtl/crc_wr_pkg.sv
// Shared types, burst constants and the CRC-8 fold helper for the DDR5 write-CRC generator.
package crc_wr_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PAD, DONE} crc_state_e;

  typedef enum logic [1:0] {MODE_X4 = 2'd0, MODE_X8 = 2'd1, MODE_X16 = 2'd2} dev_mode_e;

  localparam int BEATS_BL16 = 8;
  localparam int BEATS_BL8  = 4;
  localparam int PAD_BEATS  = 4;

  // Reserved encoding 3 behaves as x8.
  function automatic dev_mode_e norm_mode(input logic [1:0] mode);
    case (mode)
      2'd0:    return MODE_X4;
      2'd2:    return MODE_X16;
      default: return MODE_X8;
    endcase
  endfunction

  // Serial MSB-first CRC-8 over one beat of a lane: the even UI sits in data[7:0] and the
  // odd UI in data[15:8]; within a UI, DQ0 is shifted first and only nbits DQs take part.
  function automatic logic [7:0] crc8_fold(input logic [7:0]  crc,
                                           input logic [15:0] data,
                                           input logic [3:0]  nbits,
                                           input logic [7:0]  poly);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int ui = 0; ui < 2; ui++) begin
      for (int dq = 0; dq < 8; dq++) begin
        if (dq < int'(nbits)) begin
          fb = c[7] ^ data[ui*8 + dq];
          c  = {c[6:0], 1'b0};
          if (fb) c = c ^ poly;
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_lane_engine.sv
// One byte lane's CRC-8 accumulator: seed, fold one 2-UI beat, or hold.
module crc8_lane_engine
  import crc_wr_pkg::*;
#(
  parameter int         LANE_W = 8,
  parameter logic [7:0] POLY   = 8'h07,
  parameter logic [7:0] INIT   = 8'h00
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_seed,
  input  logic                i_fold,
  input  logic                i_narrow,
  input  logic [2*LANE_W-1:0] i_data,
  output logic [7:0]          o_crc
);

  logic [7:0]  r_crc;
  logic [15:0] w_uiData;
  logic [3:0]  w_nbits;
  logic [7:0]  w_next;

  // Spread the two UIs onto byte boundaries and fold them; x4 keeps only the low half of each UI.
  always_comb begin
    w_uiData              = '0;
    w_uiData[LANE_W-1:0]  = i_data[LANE_W-1:0];
    w_uiData[8 +: LANE_W] = i_data[LANE_W +: LANE_W];
    w_nbits               = i_narrow ? 4'(LANE_W/2) : 4'(LANE_W);
    w_next                = crc8_fold(r_crc, w_uiData, w_nbits, POLY);
  end

  // CRC register: reseed wins over fold, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_seed) r_crc <= INIT;
    else if (i_fold)       r_crc <= w_next;
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc_wr_burst_gen.sv
// DDR5 write-CRC generator: per-lane CRC-8 over a BL16 burst or a BL8 burst plus all-ones padding.
module crc_wr_burst_gen
  import crc_wr_pkg::*;
#(
  parameter int         NUM_LANES = 2,
  parameter int         LANE_W    = 8,
  parameter logic [7:0] POLY      = 8'h07,
  parameter logic [7:0] INIT      = 8'h00
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_crc_en,
  input  logic [2*NUM_LANES*LANE_W-1:0] i_crc_in_data,
  input  logic [1:0]                    i_mode,
  input  logic                          i_bl8,
  output logic                          o_busy,
  output logic                          o_crc_valid,
  output logic [8*NUM_LANES-1:0]        o_crc_code,
  output logic                          o_overrun
);

  localparam logic [2:0] LAST_BL16 = 3'(BEATS_BL16 - 1);
  localparam logic [2:0] LAST_BL8  = 3'(BEATS_BL8 - 1);
  localparam logic [2:0] LAST_PAD  = 3'(PAD_BEATS - 1);

  crc_state_e             r_state, w_nextState;
  logic [2:0]             r_cnt;
  dev_mode_e              r_mode;
  logic                   r_bl8;
  logic                   r_overrun;
  logic [8*NUM_LANES-1:0] r_crcCode;

  dev_mode_e              w_mode;
  logic                   w_accept;
  logic                   w_fold;
  logic                   w_seed;
  logic                   w_lastBeat;
  logic                   w_lastPad;
  logic [7:0]             w_laneCrc [NUM_LANES];
  logic [8*NUM_LANES-1:0] w_codeNow;

  // In IDLE the first beat is folded with the live mode; afterwards the latched mode rules.
  always_comb begin
    w_mode     = (r_state == IDLE) ? norm_mode(i_mode) : r_mode;
    w_accept   = i_crc_en && ((r_state == IDLE) || (r_state == DATA));
    w_fold     = w_accept || (r_state == PAD);
    w_seed     = (r_state == DONE);
    w_lastBeat = (r_cnt == (r_bl8 ? LAST_BL8 : LAST_BL16));
    w_lastPad  = (r_cnt == LAST_PAD);
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic                w_active;
    logic [2*LANE_W-1:0] w_data;

    assign w_active = (l == 0) || (w_mode == MODE_X16);
    assign w_data   = (r_state == PAD) ? '1 : i_crc_in_data[l*2*LANE_W +: 2*LANE_W];

    crc8_lane_engine #(
      .LANE_W (LANE_W),
      .POLY   (POLY),
      .INIT   (INIT)
    ) u_engine (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_seed   (w_seed),
      .i_fold   (w_fold && w_active),
      .i_narrow (w_mode == MODE_X4),
      .i_data   (w_data),
      .o_crc    (w_laneCrc[l])
    );

    assign w_codeNow[8*l +: 8] = w_active ? w_laneCrc[l] : 8'h00;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic: stalls in DATA simply hold; PAD and DONE ignore i_crc_en.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (i_crc_en) w_nextState = DATA;
      DATA: if (i_crc_en && w_lastBeat) w_nextState = r_bl8 ? PAD : DONE;
      PAD:  if (w_lastPad) w_nextState = DONE;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Beat/pad counter and the per-burst mode latch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_mode <= MODE_X4;
      r_bl8  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_crc_en) begin
          r_cnt  <= 3'd1;
          r_mode <= norm_mode(i_mode);
          r_bl8  <= i_bl8;
        end
        DATA: if (i_crc_en) r_cnt <= w_lastBeat ? 3'd0 : r_cnt + 3'd1;
        PAD:  r_cnt <= w_lastPad ? 3'd0 : r_cnt + 3'd1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Sticky overrun flag and the code held between valid pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
      r_crcCode <= '0;
    end else begin
      if (i_crc_en && o_busy) r_overrun <= 1'b1;
      if (r_state == DONE)    r_crcCode <= w_codeNow;
    end
  end

  // Outputs: in DONE the lane registers are presented directly, afterwards the held copy.
  always_comb begin
    o_busy      = (r_state == PAD) || (r_state == DONE);
    o_crc_valid = (r_state == DONE);
    o_crc_code  = o_crc_valid ? w_codeNow : r_crcCode;
    o_overrun   = r_overrun;
  end

endmodule

// File: tb/tb_crc_wr_burst_gen.sv
// Scoreboard bench for crc_wr_burst_gen (2 lanes of 8 DQ).
module tb_crc_wr_burst_gen;

  typedef logic [31:0] beats_t [8];

  typedef struct {
    logic [15:0] code;
    int          cyc;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_crc_en = 1'b0;
  logic [31:0] i_crc_in_data = '0;
  logic [1:0]  i_mode = 2'd1;
  logic        i_bl8 = 1'b0;
  logic        o_busy;
  logic        o_crc_valid;
  logic [15:0] o_crc_code;
  logic        o_overrun;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t expQ [$];

  crc_wr_burst_gen #(
    .NUM_LANES (2),
    .LANE_W    (8),
    .POLY      (8'h07),
    .INIT      (8'h00)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_crc_en      (i_crc_en),
    .i_crc_in_data (i_crc_in_data),
    .i_mode        (i_mode),
    .i_bl8         (i_bl8),
    .o_busy        (o_busy),
    .o_crc_valid   (o_crc_valid),
    .o_crc_code    (o_crc_code),
    .o_overrun     (o_overrun)
  );

  // 10 ns clock.
  always #5 i_clk = ~i_clk;

  // Count rising edges so latencies can be checked in absolute cycles.
  always @(posedge i_clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; the DUT samples them on the following rising edge.
  task automatic applyStimulus(input logic en, input logic [31:0] data);
    i_crc_en      = en;
    i_crc_in_data = data;
    @(posedge i_clk);
    #1;
  endtask

  // Reference CRC: bit-serial over the whole burst, BL8 padded with four all-ones beats.
  function automatic logic [15:0] modelCrc(input logic [1:0] mode, input logic bl8, input beats_t beats);
    logic [15:0] res;
    logic [15:0] laneData;
    logic [7:0]  c;
    logic        b;
    int          w;
    res = '0;
    w   = (mode == 2'd0) ? 4 : 8;
    for (int lane = 0; lane < 2; lane++) begin
      if (lane == 1 && mode != 2'd2) continue;
      c = 8'h00;
      for (int beat = 0; beat < 8; beat++) begin
        laneData = (bl8 && beat >= 4) ? 16'hFFFF : beats[beat][lane*16 +: 16];
        for (int ui = 0; ui < 2; ui++) begin
          for (int dq = 0; dq < w; dq++) begin
            b = laneData[ui*8 + dq];
            c = (c[7] ^ b) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
          end
        end
      end
      res[lane*8 +: 8] = c;
    end
    return res;
  endfunction

  // Drive a full burst (optionally with a stall and mid-burst mode/BL changes) and queue the expectation.
  task automatic runBurst(input logic [1:0] mode, input logic bl8, input beats_t beats,
                          input int stallAt, input int stallLen, input logic [1:0] midMode,
                          input logic [15:0] expCode);
    int   n;
    exp_t e;
    n = bl8 ? 4 : 8;
    for (int b = 0; b < n; b++) begin
      i_mode = (b == 0) ? mode : midMode;
      i_bl8  = (b == 0 || midMode == mode) ? bl8 : ~bl8;
      applyStimulus(1'b1, beats[b]);
      if (b == stallAt) repeat (stallLen) applyStimulus(1'b0, $urandom);
    end
    e.code = expCode;
    e.cyc  = cyc + (bl8 ? 4 : 0);
    expQ.push_back(e);
    i_crc_en = 1'b0;
  endtask

  // Output monitor: every valid pulse must match the oldest queued expectation, code and timing.
  always @(negedge i_clk) begin
    if (o_crc_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", 32'(o_crc_code), 32'hDEAD);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("crc_code", 32'(o_crc_code), 32'(e.code));
        checkOutput("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  beats_t bz, bo, br;
  int     waitCnt;

  initial begin
    // Reset and check idle outputs.
    i_reset = 1'b1;
    repeat (3) applyStimulus(1'b0, '0);
    i_reset = 1'b0;
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_valid", 32'(o_crc_valid), 32'd0);
    checkOutput("rst_code", 32'(o_crc_code), 32'd0);
    checkOutput("rst_overrun", 32'(o_overrun), 32'd0);
    applyStimulus(1'b0, '0);

    foreach (bz[i]) bz[i] = '0;
    foreach (bo[i]) bo[i] = '1;

    // x8 BL16 all zeros.
    runBurst(2'd1, 1'b0, bz, -1, 0, 2'd1, 16'h0000);
    applyStimulus(1'b0, '0);

    // x8 BL16 single one in the very last bit shifted.
    br = bz; br[7][15] = 1'b1;
    runBurst(2'd1, 1'b0, br, -1, 0, 2'd1, 16'h0007);
    applyStimulus(1'b0, '0);

    // x16 BL16, same bit on lane 1 only.
    br = bz; br[7][31] = 1'b1;
    runBurst(2'd2, 1'b0, br, -1, 0, 2'd2, 16'h0700);
    applyStimulus(1'b0, '0);

    // x8 and x4 BL16 all ones (inactive lane reads zero, x4 ignores upper nibbles).
    runBurst(2'd1, 1'b0, bo, -1, 0, 2'd1, 16'h00FA);
    applyStimulus(1'b0, '0);
    runBurst(2'd0, 1'b0, bo, -1, 0, 2'd0, 16'h00D7);
    applyStimulus(1'b0, '0);

    // x4 BL8: busy through 4 PAD cycles plus DONE.
    runBurst(2'd0, 1'b1, bo, -1, 0, 2'd0, 16'h00D7);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bl8_busy_high", 32'(o_busy), 32'd1);
      applyStimulus(1'b0, '0);
    end
    checkOutput("bl8_busy_low", 32'(o_busy), 32'd0);
    applyStimulus(1'b0, '0);

    // x8 BL16 with a 3-cycle stall after beat 3, then a back-to-back x16 random burst.
    runBurst(2'd1, 1'b0, bo, 2, 3, 2'd1, 16'h00FA);
    applyStimulus(1'b0, '0);
    foreach (br[i]) br[i] = $urandom;
    runBurst(2'd2, 1'b0, br, -1, 0, 2'd2, modelCrc(2'd2, 1'b0, br));
    applyStimulus(1'b0, '0);
    checkOutput("b2b_no_overrun", 32'(o_overrun), 32'd0);

    // x4 BL8 with a beat arriving during PAD: dropped, overrun set.
    runBurst(2'd0, 1'b1, bo, -1, 0, 2'd0, 16'h00D7);
    applyStimulus(1'b1, 32'h1234_5678);
    repeat (5) applyStimulus(1'b0, '0);
    checkOutput("overrun_set", 32'(o_overrun), 32'd1);

    // Reserved mode 3 behaves as x8.
    foreach (br[i]) br[i] = $urandom;
    runBurst(2'd3, 1'b0, br, -1, 0, 2'd3, modelCrc(2'd1, 1'b0, br));
    applyStimulus(1'b0, '0);

    // x8 BL8 with mode and BL changed after the first beat: latched values win.
    foreach (br[i]) br[i] = $urandom;
    runBurst(2'd1, 1'b1, br, -1, 0, 2'd2, modelCrc(2'd1, 1'b1, br));
    repeat (6) applyStimulus(1'b0, '0);

    // Reset on beat 5 of a BL16 burst: no valid, everything back to reset values.
    i_mode = 2'd1;
    i_bl8  = 1'b0;
    for (int b = 0; b < 4; b++) applyStimulus(1'b1, 32'hFFFF_FFFF);
    i_reset = 1'b1;
    applyStimulus(1'b1, 32'hFFFF_FFFF);
    i_reset = 1'b0;
    checkOutput("midrst_busy", 32'(o_busy), 32'd0);
    checkOutput("midrst_code", 32'(o_crc_code), 32'd0);
    checkOutput("midrst_overrun", 32'(o_overrun), 32'd0);
    repeat (10) applyStimulus(1'b0, '0);
    runBurst(2'd1, 1'b0, bz, -1, 0, 2'd1, 16'h0000);
    applyStimulus(1'b0, '0);
    checkOutput("held_code", 32'(o_crc_code), 32'd0);

    // Drain the scoreboard within a bounded window.
    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 50) begin
      applyStimulus(1'b0, '0);
      waitCnt++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
